// File: rtl/sdram_arbiter.sv
// Two-client arbiter for the SDRAM controller command port: the display refill client has real-time priority,
// and the Mandelbrot processor owns the port by default through its request/yield handshake.
module sdram_arbiter #(
   parameter int PROC_MIN_SLOT = 16,
   parameter int SLOT_W        = 8
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Disp_Req,
   input  logic [1:0]  i_Disp_Command,
   input  logic [21:0] i_Disp_Address,
   input  logic [31:0] i_Disp_Write_Data,
   output logic        o_Disp_Grant,
   output logic        o_Disp_Read_Valid,
   output logic        o_Disp_Write_Done,
   output logic        o_Proc_SDRAM_Requested,
   input  logic        i_Proc_Yield,
   input  logic [1:0]  i_Proc_Command,
   input  logic [21:0] i_Proc_Address,
   input  logic [31:0] i_Proc_Write_Data,
   output logic        o_Proc_Read_Valid,
   output logic        o_Proc_Write_Done,
   output logic [1:0]  o_Command,
   output logic [21:0] o_Data_Address,
   output logic [31:0] o_Data_Write,
   input  logic        i_Data_Read_Valid,
   input  logic        i_Data_Write_Done,
   output logic        o_Protocol_Error,
   output logic [15:0] o_Disp_Grant_Count
);

   // Command encoding shared with the SDRAM controller.
   localparam logic [1:0] CMD_IDLE = 2'd0;

   typedef enum logic [1:0] {ST_PROC, ST_REQ, ST_DISP} state_t;

   state_t            r_state;
   logic [SLOT_W-1:0] r_slot;
   logic              r_first_disp;
   logic              r_disp_grant;
   logic              r_proc_req;
   logic              r_error;
   logic [15:0]       r_grant_cnt;

   logic w_owner_disp;
   logic w_disp_cmd_err;
   logic w_yield_err;

   assign w_owner_disp   = (r_state == ST_DISP);
   assign w_disp_cmd_err = !w_owner_disp && (i_Disp_Command != CMD_IDLE);
   // The processor still driving a command on the first display cycle means it never really yielded.
   assign w_yield_err    = r_first_disp && (i_Proc_Command != CMD_IDLE);

   always_comb begin
      o_Command      = i_Proc_Command;
      o_Data_Address = i_Proc_Address;
      o_Data_Write   = i_Proc_Write_Data;
      if (w_owner_disp) begin
         o_Command      = w_yield_err ? CMD_IDLE : i_Disp_Command;
         o_Data_Address = i_Disp_Address;
         o_Data_Write   = i_Disp_Write_Data;
      end
   end

   assign o_Disp_Read_Valid      = w_owner_disp & i_Data_Read_Valid;
   assign o_Disp_Write_Done      = w_owner_disp & i_Data_Write_Done;
   assign o_Proc_Read_Valid      = !w_owner_disp & i_Data_Read_Valid;
   assign o_Proc_Write_Done      = !w_owner_disp & i_Data_Write_Done;
   assign o_Disp_Grant           = r_disp_grant;
   assign o_Proc_SDRAM_Requested = r_proc_req;
   assign o_Protocol_Error       = r_error;
   assign o_Disp_Grant_Count     = r_grant_cnt;

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         r_state      <= ST_PROC;
         r_slot       <= '0;
         r_first_disp <= 1'b0;
         r_disp_grant <= 1'b0;
         r_proc_req   <= 1'b0;
         r_error      <= 1'b0;
         r_grant_cnt  <= '0;
      end else begin
         if (w_disp_cmd_err || w_yield_err)
            r_error <= 1'b1;
         r_first_disp <= 1'b0;
         case (r_state)
            ST_PROC: begin
               if (r_slot != '0)
                  r_slot <= r_slot - 1'b1;
               if (i_Disp_Req && (r_slot == '0)) begin
                  r_state    <= ST_REQ;
                  r_proc_req <= 1'b1;
               end
            end
            ST_REQ: begin
               // A withdrawn request wins over a same-cycle yield.
               if (!i_Disp_Req) begin
                  r_state    <= ST_PROC;
                  r_proc_req <= 1'b0;
               end else if (i_Proc_Yield) begin
                  r_state      <= ST_DISP;
                  r_disp_grant <= 1'b1;
                  r_first_disp <= 1'b1;
                  r_grant_cnt  <= r_grant_cnt + 16'd1;
               end
            end
            ST_DISP: begin
               if (!i_Disp_Req && (i_Disp_Command == CMD_IDLE)) begin
                  r_state      <= ST_PROC;
                  r_slot       <= SLOT_W'(PROC_MIN_SLOT);
                  r_disp_grant <= 1'b0;
                  r_proc_req   <= 1'b0;
               end
            end
            default: r_state <= ST_PROC;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed-vector bench for sdram_arbiter: ownership handshake, routing, slot hold-off, protocol errors and
// reset in the middle of a burst.
module tb_sdram_arbiter;

   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd1;
   localparam logic [1:0] CMD_WRITE = 2'd2;

   logic        clk = 1'b0;
   logic        rst;
   logic        disp_req;
   logic [1:0]  disp_cmd;
   logic [21:0] disp_addr;
   logic [31:0] disp_wdata;
   logic        disp_grant, disp_rv, disp_wd;
   logic        proc_requested;
   logic        proc_yield;
   logic [1:0]  proc_cmd;
   logic [21:0] proc_addr;
   logic [31:0] proc_wdata;
   logic        proc_rv, proc_wd;
   logic [1:0]  cmd;
   logic [21:0] addr;
   logic [31:0] wdata;
   logic        rd_valid, wr_done;
   logic        perr;
   logic [15:0] gcnt;

   int n_cmp = 0;
   int n_err = 0;
   int lat;

   always #5 clk = ~clk;

   sdram_arbiter #(.PROC_MIN_SLOT(16), .SLOT_W(8)) dut (
      .i_Clk(clk), .i_Reset(rst),
      .i_Disp_Req(disp_req), .i_Disp_Command(disp_cmd), .i_Disp_Address(disp_addr),
      .i_Disp_Write_Data(disp_wdata), .o_Disp_Grant(disp_grant), .o_Disp_Read_Valid(disp_rv),
      .o_Disp_Write_Done(disp_wd), .o_Proc_SDRAM_Requested(proc_requested), .i_Proc_Yield(proc_yield),
      .i_Proc_Command(proc_cmd), .i_Proc_Address(proc_addr), .i_Proc_Write_Data(proc_wdata),
      .o_Proc_Read_Valid(proc_rv), .o_Proc_Write_Done(proc_wd), .o_Command(cmd),
      .o_Data_Address(addr), .o_Data_Write(wdata), .i_Data_Read_Valid(rd_valid),
      .i_Data_Write_Done(wr_done), .o_Protocol_Error(perr), .o_Disp_Grant_Count(gcnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1ns after the rising edge; checks land 1ns later, well clear of both edges.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst = 1'b1; disp_req = 1'b0; disp_cmd = CMD_IDLE; disp_addr = '0; disp_wdata = '0;
      proc_yield = 1'b0; proc_cmd = CMD_IDLE; proc_addr = '0; proc_wdata = '0;
      rd_valid = 1'b0; wr_done = 1'b0;
      tick(); tick();

      // mux follows the processor while held in reset
      proc_cmd = CMD_READ; proc_addr = 22'h000100; proc_wdata = 32'h11112222;
      settle();
      chk("rst_cmd",   32'(cmd),  32'(CMD_READ));
      chk("rst_addr",  32'(addr), 32'h000100);
      chk("rst_grant", 32'(disp_grant), 0);
      chk("rst_req",   32'(proc_requested), 0);
      chk("rst_err",   32'(perr), 0);
      chk("rst_cnt",   32'(gcnt), 0);

      // processor read at 0x000100
      tick(); rst = 1'b0;
      tick();
      rd_valid = 1'b1;
      settle();
      chk("p_cmd",   32'(cmd),  32'(CMD_READ));
      chk("p_addr",  32'(addr), 32'h000100);
      chk("p_rv",    32'(proc_rv), 1);
      chk("p_drv",   32'(disp_rv), 0);
      chk("p_grant", 32'(disp_grant), 0);

      // display requests mid-burst; processor finishes 3 words before yielding
      tick();
      proc_cmd = CMD_IDLE; disp_req = 1'b1;
      tick();
      settle();
      chk("req_one_cycle", 32'(proc_requested), 1);
      for (int i = 0; i < 3; i++) begin
         chk("burst_grant0", 32'(disp_grant), 0);
         chk("burst_prv",    32'(proc_rv), 1);
         tick();
      end
      rd_valid = 1'b0; proc_yield = 1'b1;
      settle();
      chk("yield_grant0", 32'(disp_grant), 0);
      tick();
      settle();
      chk("grant_after_yield", 32'(disp_grant), 1);
      chk("grant_cnt1",        32'(gcnt), 1);
      chk("disp_req_held",     32'(proc_requested), 1);
      rd_valid = 1'b1;
      settle();
      chk("disp_rv_routed", 32'(disp_rv), 1);
      chk("proc_rv_blocked", 32'(proc_rv), 0);
      rd_valid = 1'b0;

      // display write burst at 0x01F3FF
      tick();
      disp_cmd = CMD_WRITE; disp_addr = 22'h01F3FF; disp_wdata = 32'hCAFEBABE; wr_done = 1'b1;
      settle();
      chk("dw_cmd",   32'(cmd),   32'(CMD_WRITE));
      chk("dw_addr",  32'(addr),  32'h01F3FF);
      chk("dw_data",  32'(wdata), 32'hCAFEBABE);
      chk("dw_done",  32'(disp_wd), 1);
      chk("dw_pdone", 32'(proc_wd), 0);
      // request dropped while command still active: ownership holds
      tick();
      disp_req = 1'b0;
      tick();
      settle();
      chk("hold_nonidle", 32'(disp_grant), 1);
      disp_cmd = CMD_IDLE; wr_done = 1'b0;
      tick();
      proc_yield = 1'b0;
      settle();
      chk("rel_grant", 32'(disp_grant), 0);
      chk("rel_req",   32'(proc_requested), 0);
      chk("rel_mux",   32'(addr), 32'h000100);
      chk("rel_err",   32'(perr), 0);

      // immediate re-request: 17 PROC cycles (slot 16..0) before Requested rises
      disp_req = 1'b1;
      lat = 0;
      settle();
      while (!proc_requested && lat < 40) begin
         tick();
         lat++;
      end
      chk("slot_latency", 32'(lat), 17);
      chk("slot_cnt_same", 32'(gcnt), 1);

      // withdraw from REQ: no slot reload, so re-request is honoured one cycle later
      disp_req = 1'b0;
      tick();
      settle();
      chk("withdraw_req", 32'(proc_requested), 0);
      disp_req = 1'b1;
      tick();
      settle();
      chk("no_reload_req", 32'(proc_requested), 1);
      disp_req = 1'b0;
      tick();

      // display drives a read without grant
      proc_cmd = CMD_WRITE; proc_addr = 22'h2AAAA; disp_cmd = CMD_READ; disp_addr = 22'h000055;
      settle();
      chk("ng_cmd",  32'(cmd),  32'(CMD_WRITE));
      chk("ng_addr", 32'(addr), 32'h2AAAA);
      chk("ng_err0", 32'(perr), 0);
      tick();
      disp_cmd = CMD_IDLE; proc_cmd = CMD_IDLE;
      settle();
      chk("ng_err1", 32'(perr), 1);
      tick(); tick(); tick();
      chk("ng_err_sticky", 32'(perr), 1);

      // second grant, then reset mid-burst
      disp_req = 1'b1; proc_yield = 1'b1;
      tick(); tick();
      settle();
      chk("g2_grant", 32'(disp_grant), 1);
      chk("g2_cnt",   32'(gcnt), 2);
      disp_cmd = CMD_READ; disp_addr = 22'h000200; rd_valid = 1'b1;
      tick();
      proc_addr = 22'h000300; proc_cmd = CMD_IDLE;
      rst = 1'b1;
      settle();
      chk("mr_grant",  32'(disp_grant), 0);
      chk("mr_req",    32'(proc_requested), 0);
      chk("mr_err",    32'(perr), 0);
      chk("mr_cnt",    32'(gcnt), 0);
      chk("mr_addr",   32'(addr), 32'h000300);
      chk("mr_prv",    32'(proc_rv), 1);
      disp_cmd = CMD_IDLE; rd_valid = 1'b0; proc_yield = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      settle();
      chk("post_rst_req", 32'(proc_requested), 1);

      // yield violation: processor still commanding on the first display cycle
      proc_yield = 1'b1; proc_cmd = CMD_READ;
      tick();
      disp_cmd = CMD_WRITE;
      settle();
      chk("yv_grant", 32'(disp_grant), 1);
      chk("yv_cnt",   32'(gcnt), 1);
      chk("yv_force", 32'(cmd), 32'(CMD_IDLE));
      chk("yv_err0",  32'(perr), 0);
      tick();
      proc_cmd = CMD_IDLE;
      settle();
      chk("yv_err1",  32'(perr), 1);
      chk("yv_cmd2",  32'(cmd), 32'(CMD_WRITE));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between two clients:
  - the display refill client, which has real-time priority;
  - the Mandelbrot processor client, which uses the existing request/yield handshake (i_SDRAM_Requested / o_SDRAM_Yield).
- The processor owns the port by default. The display takes it by requesting, waiting for the processor to yield, running its bursts, then releasing.
- Sits between both clients and the SDRAM controller; routes commands, addresses, write data and completion strobes.

Parameters:
- PROC_MIN_SLOT, 16: minimum number of cycles the processor keeps ownership after a display release before the display may pre-empt again.
- SLOT_W, 8: width of the slot counter; must satisfy PROC_MIN_SLOT < 2^SLOT_W.

Ports:
- i_Clk  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Disp_Req  in  1  display wants the SDRAM port
- i_Disp_Command  in  2  display command (CMD_IDLE/CMD_READ/CMD_WRITE from sdram.vh)
- i_Disp_Address  in  22  display address
- i_Disp_Write_Data  in  32  display write data
- o_Disp_Grant  out  1  display owns the port
- o_Disp_Read_Valid  out  1  routed i_Data_Read_Valid
- o_Disp_Write_Done  out  1  routed i_Data_Write_Done
- o_Proc_SDRAM_Requested  out  1  drives processor i_SDRAM_Requested
- i_Proc_Yield  in  1  processor o_SDRAM_Yield
- i_Proc_Command  in  2  processor command
- i_Proc_Address  in  22  processor address
- i_Proc_Write_Data  in  32  processor write data
- o_Proc_Read_Valid  out  1  routed i_Data_Read_Valid
- o_Proc_Write_Done  out  1  routed i_Data_Write_Done
- o_Command  out  2  to controller
- o_Data_Address  out  22  to controller
- o_Data_Write  out  32  to controller
- i_Data_Read_Valid  in  1  from controller
- i_Data_Write_Done  in  1  from controller
- o_Protocol_Error  out  1  sticky error flag
- o_Disp_Grant_Count  out  16  number of display grants, wraps at 16 bits

Behaviour:
- State register: PROC, REQ, DISP.
- Owner is registered. The controller-side mux is combinational from the owner; owner = DISP only in state DISP.
- Reset (asynchronous, any time, including mid-burst):
  - state = PROC; slot counter = 0;
  - o_Disp_Grant = 0, o_Proc_SDRAM_Requested = 0, o_Protocol_Error = 0, o_Disp_Grant_Count = 0;
  - during reset, o_Command / o_Data_Address / o_Data_Write follow the processor inputs.
- PROC:
  - mux selects the processor; o_Proc_Read_Valid = i_Data_Read_Valid; o_Proc_Write_Done = i_Data_Write_Done; display strobes = 0.
  - Slot counter decrements to 0 and saturates there.
  - If i_Disp_Req && slot == 0: go to REQ next cycle.
- REQ:
  - o_Proc_SDRAM_Requested = 1; mux still selects the processor, so any in-flight processor burst completes normally.
  - If i_Proc_Yield: go to DISP next cycle and increment o_Disp_Grant_Count (mod 2^16).
  - If i_Disp_Req drops first: return to PROC; Requested deasserts; slot is not reloaded.
- DISP:
  - o_Disp_Grant = 1; o_Proc_SDRAM_Requested stays 1 so the processor remains idle; mux selects the display; strobes route to the display only.
  - If !i_Disp_Req && i_Disp_Command == CMD_IDLE: go to PROC next cycle, slot = PROC_MIN_SLOT, Requested and Grant deassert.
  - If i_Disp_Req drops while the display command is non-idle: hold DISP until the command returns to CMD_IDLE.
- Grant latency:
  - i_Disp_Req rising in PROC with slot 0 and processor idle gives Requested = 1 one cycle later.
  - With a combinational yield, Grant = 1 two cycles after the request.
  - The display must not issue a command before it samples Grant.
- Command forcing:
  - A non-idle i_Disp_Command while not in DISP is never forwarded and sets o_Protocol_Error (sticky until reset).
  - o_Command is forced to CMD_IDLE in the first DISP cycle if the processor command is non-idle. This is a yield violation and also sets o_Protocol_Error.
- Simultaneous events: a display release and a new display request in the same cycle are treated as a release; re-arbitration waits PROC_MIN_SLOT cycles.
- All state is registered; no combinational path from i_Disp_Req to o_Command.

Test Plan:
- Reset, processor issuing CMD_READ at 0x000100 → o_Command = CMD_READ, o_Data_Address = 0x000100; read-valid strobes reach only o_Proc_Read_Valid; Grant = 0.
- Display requests while the processor is mid-burst (3 of 8 words left) → Requested = 1; Grant stays 0 until the burst ends and Yield = 1; Grant = 1 on the next cycle; o_Disp_Grant_Count = 1.
- Display runs a write burst at 0x01F3FF then drops its request → o_Data_Write = display data; Write_Done routes to the display; one cycle later owner = PROC and Requested = 0.
- Display re-requests immediately after release → no Requested assertion for 16 cycles; asserted on cycle 17.
- Display drives CMD_READ without grant → o_Command unchanged from the processor; o_Protocol_Error = 1 and remains 1 until reset.
- Reset asserted in DISP mid-burst → next cycle Grant = 0, Requested = 0, error = 0, count = 0; mux on the processor; a display request is honoured without slot delay.
